// File: rtl/pipelined_preadd_mul_logic_pkg.sv
// ----------------------------------------------------------------------------
// pipelined_preadd_mul_logic_pkg
// Purpose : shared types and constants for the pre-add / multiply / logic
//           pipeline.
// Contents: op_e      - selects the bitwise operation applied after the multiply
//           MAX_STAGES - deepest pipeline the top module accepts
// ----------------------------------------------------------------------------
package pipelined_preadd_mul_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_PASS = 2'd3
    } op_e;

    localparam int MAX_STAGES = 8;

endpackage

// File: rtl/pipelined_preadd_mul_logic_pipe_stage.sv
// ----------------------------------------------------------------------------
// pipe_stage
// Purpose : one register slot of the output pipeline: a data word plus its
//           valid bit. Loads both when load_i is high, otherwise holds.
// Ports   : clk     - clock, rising edge
//           rst_n   - asynchronous active-low reset (clears valid and data)
//           load_i  - capture vld_i/data_i this cycle
//           vld_i   - valid bit from the upstream slot
//           data_i  - data word from the upstream slot
//           vld_o   - this slot is occupied
//           data_o  - word held in this slot
// ----------------------------------------------------------------------------
module pipe_stage
    import pipelined_preadd_mul_logic_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load_i) begin
            vld_d  = vld_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipelined_preadd_mul_logic.sv
// ----------------------------------------------------------------------------
// pipelined_preadd_mul_logic
// Purpose : computes L(((sub ? d-a : d+a) * b) mod 2^WIDTH, c) where L is
//           AND / OR / XOR with c or a pass-through, then carries the result
//           through STAGES register slots with valid/ready flow control.
//           All arithmetic wraps modulo 2^WIDTH.
// Ports   : clk, rst_n          - clock and asynchronous active-low reset
//           in_valid / in_ready - operand beat handshake
//           a, b, c, d          - unsigned operands (WIDTH bits)
//           op                  - op_e encoding of the logic operation
//           sub                 - 0: d+a, 1: d-a in the pre-adder
//           out_valid/out_ready - result beat handshake
//           out                 - result, driven straight from the last slot
// ----------------------------------------------------------------------------
module pipelined_preadd_mul_logic
    import pipelined_preadd_mul_logic_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("pipelined_preadd_mul_logic: STAGES out of range");
    end
    if (WIDTH < 2 || WIDTH > 27) begin : g_bad_width
        $error("pipelined_preadd_mul_logic: WIDTH out of range");
    end

    // Full product then keep the low WIDTH bits: the wrap is explicit here
    // rather than relying on context-width truncation.
    function automatic logic [WIDTH-1:0] mul_wrap(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] full;
        full = x * y;
        return full[WIDTH-1:0];
    endfunction

    op_e              op_sel;
    logic [WIDTH-1:0] pre_sum;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] result_d;

    logic [STAGES-1:0] stage_vld;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [STAGES-1:0] load;

    assign op_sel = op_e'(op);

    // Datapath: the whole computation finishes before the first slot, so
    // the slots only delay the result.
    always_comb begin
        pre_sum  = sub ? (d - a) : (d + a);
        prod     = mul_wrap(pre_sum, b);
        result_d = prod;
        unique case (op_sel)
            OP_AND:  result_d = prod & c;
            OP_OR:   result_d = prod | c;
            OP_XOR:  result_d = prod ^ c;
            OP_PASS: result_d = prod;
        endcase
    end

    // Slot k may load when the output drains or any slot at or after k is
    // empty; expanding the chain this way avoids a self-referencing vector.
    always_comb begin
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            load[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!stage_vld[j]) load[k] = 1'b1;
            end
        end
    end

    assign in_ready = load[0];

    // Stage boundaries: slot 0 captures the datapath result, slots 1..N-1
    // take the word from the slot before them.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_in;
        logic [WIDTH-1:0] data_in;

        if (k == 0) begin : g_first
            assign vld_in  = in_valid;
            assign data_in = result_d;
        end else begin : g_rest
            assign vld_in  = stage_vld[k-1];
            assign data_in = stage_data[k-1];
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load[k]),
            .vld_i  (vld_in),
            .data_i (data_in),
            .vld_o  (stage_vld[k]),
            .data_o (stage_data[k])
        );
    end

    assign out_valid = stage_vld[STAGES-1];
    assign out       = stage_data[STAGES-1];

endmodule

// File: tb/tb_pipelined_preadd_mul_logic.sv
module tb_pipelined_preadd_mul_logic;
    import pipelined_preadd_mul_logic_pkg::*;

    localparam int W0 = 9;
    localparam int S0 = 3;
    localparam int W1 = 16;
    localparam int S1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT 0: WIDTH=9, STAGES=3
    logic          in_valid, in_ready, sub, out_valid, out_ready;
    logic [W0-1:0] a, b, c, d, out;
    logic [1:0]    op;

    // DUT 1: WIDTH=16, STAGES=1
    logic          s1_in_valid, s1_in_ready, s1_sub, s1_out_valid, s1_out_ready;
    logic [W1-1:0] s1_a, s1_b, s1_c, s1_d, s1_out;
    logic [1:0]    s1_op;

    pipelined_preadd_mul_logic #(.WIDTH(W0), .STAGES(S0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .op(op), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    pipelined_preadd_mul_logic #(.WIDTH(W1), .STAGES(S1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .a(s1_a), .b(s1_b), .c(s1_c), .d(s1_d), .op(s1_op), .sub(s1_sub),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out(s1_out)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference: plain integer arithmetic, reduced modulo 2^w.
    function automatic longint unsigned model(int w, longint unsigned ma, longint unsigned mb,
                                              longint unsigned mc, longint unsigned md,
                                              int mop, bit msub);
        longint unsigned m, pre, p;
        m   = (64'd1 << w) - 64'd1;
        pre = (msub ? (md - ma) : (md + ma)) & m;
        p   = (pre * mb) & m;
        case (mop)
            0:       return p & mc;
            1:       return p | mc;
            2:       return p ^ mc;
            default: return p;
        endcase
    endfunction

    // Scoreboard capture: expected value of every accepted beat and every
    // delivered output, in order.
    logic [W0-1:0] exp_q[$], obs_q[$];
    logic [W1-1:0] exp1_q[$], obs1_q[$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(W0'(model(W0, a, b, c, d, op, sub)));
            if (out_valid && out_ready) obs_q.push_back(out);
            if (s1_in_valid && s1_in_ready)
                exp1_q.push_back(W1'(model(W1, s1_a, s1_b, s1_c, s1_d, s1_op, s1_sub)));
            if (s1_out_valid && s1_out_ready) obs1_q.push_back(s1_out);
        end
    end

    task automatic clear_queues();
        exp_q.delete(); obs_q.delete(); exp1_q.delete(); obs1_q.delete();
    endtask

    task automatic drive_rand0();
        a = W0'($urandom); b = W0'($urandom); c = W0'($urandom); d = W0'($urandom);
        op = 2'($urandom); sub = 1'($urandom);
    endtask

    task automatic drive_rand1();
        s1_a = W1'($urandom); s1_b = W1'($urandom); s1_c = W1'($urandom); s1_d = W1'($urandom);
        s1_op = 2'($urandom); s1_sub = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c = '0; d = '0; op = '0; sub = 1'b0;
        s1_in_valid = 1'b0; s1_out_ready = 1'b1; s1_a = '0; s1_b = '0; s1_c = '0; s1_d = '0;
        s1_op = '0; s1_sub = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
        n_total++; if (out !== 9'h000) $display("FAIL reset_out got=%h want=000", out); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
        n_total++; if (s1_out_valid !== 1'b0) $display("FAIL reset_s1_out_valid got=%b want=0", s1_out_valid); else n_pass++;
        n_total++; if (s1_out !== 16'h0000) $display("FAIL reset_s1_out got=%h want=0000", s1_out); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got=%b want=0", out_valid); else n_pass++;
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        clear_queues();
        a = 9'd3; d = 9'd5; b = 9'd7; c = 9'h1FF; op = OP_AND; sub = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= S0; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'(i == S0))
                $display("FAIL latency_cycle%0d out_valid got=%b want=%b", i, out_valid, (i == S0));
            else n_pass++;
        end
        n_total++; if (out !== 9'h038) $display("FAIL basic_and_value got=%h want=038", out); else n_pass++;
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        clear_queues();
        a = 9'h1FF; d = 9'd1; b = 9'd9; c = W0'($urandom); op = OP_PASS; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        d = 9'd2; a = 9'd5; b = 9'd2; sub = 1'b1; c = 9'h005; op = OP_OR;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_total++; if (obs_q.size() != 2) $display("FAIL wrap_count got=%0d want=2", obs_q.size()); else n_pass++;
        n_total++; if (obs_q[0] !== 9'h000) $display("FAIL wrap_add_pass got=%h want=000", obs_q[0]); else n_pass++;
        n_total++; if (obs_q[1] !== 9'h1FF) $display("FAIL wrap_sub_or got=%h want=1ff", obs_q[1]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int vcount, first_idx, last_idx;
        vcount = 0; first_idx = -1; last_idx = -1;
        @(posedge clk); #1;
        clear_queues();
        out_ready = 1'b1;
        fork
            begin
                for (int j = 0; j < 10; j++) begin
                    drive_rand0(); op = 2'(j % 4); in_valid = 1'b1;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        vcount++;
                        if (first_idx < 0) first_idx = k;
                        last_idx = k;
                    end
                end
            end
        join
        n_total++; if (vcount != 10) $display("FAIL b2b_valid_cycles got=%0d want=10", vcount); else n_pass++;
        n_total++;
        if (last_idx - first_idx != 9) $display("FAIL b2b_contiguous span=%0d want=9", last_idx - first_idx);
        else n_pass++;
        n_total++; if (obs_q.size() != 10) $display("FAIL b2b_count got=%0d want=10", obs_q.size()); else n_pass++;
        for (int j = 0; j < 10; j++) begin
            n_total++;
            if (obs_q[j] !== exp_q[j]) $display("FAIL b2b_beat%0d got=%h want=%h", j, obs_q[j], exp_q[j]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int acc_cnt, extra, guard;
        logic acc;
        logic [W0-1:0] held;
        held = '0;
        @(posedge clk); #1;
        clear_queues();
        out_ready = 1'b0;
        drive_rand0(); in_valid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) acc_cnt++;
            if (i == 3) held = out;
            if (i == 4) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got=%b want=0", in_ready); else n_pass++;
                n_total++; if (out !== held) $display("FAIL bp_out_stable got=%h want=%h", out, held); else n_pass++;
                n_total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid_held got=%b want=1", out_valid); else n_pass++;
            end
            @(posedge clk); #1;
            if (acc) drive_rand0();
        end
        n_total++; if (acc_cnt != S0) $display("FAIL bp_accepts got=%0d want=%0d", acc_cnt, S0); else n_pass++;
        n_total++;
        if (exp_q.size() < 1 || held !== exp_q[0]) $display("FAIL bp_head_value got=%h want=%h", held, exp_q[0]);
        else n_pass++;
        out_ready = 1'b1;
        extra = 0; guard = 0;
        while (extra < 2 && guard < 20) begin
            @(negedge clk);
            if (guard == 0) begin
                n_total++;
                if (in_ready !== 1'b1) $display("FAIL bp_accept_while_drain got=%b want=1", in_ready); else n_pass++;
            end
            acc = in_valid && in_ready;
            if (acc) extra++;
            guard++;
            @(posedge clk); #1;
            if (acc) begin
                if (extra < 2) drive_rand0(); else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_total++; if (extra != 2) $display("FAIL bp_extra_accepts got=%0d want=2", extra); else n_pass++;
        repeat (8) @(negedge clk);
        n_total++; if (obs_q.size() != 5) $display("FAIL bp_drain_count got=%0d want=5", obs_q.size()); else n_pass++;
        for (int j = 0; j < 5; j++) begin
            n_total++;
            if (obs_q[j] !== exp_q[j]) $display("FAIL bp_beat%0d got=%h want=%h", j, obs_q[j], exp_q[j]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        @(posedge clk); #1;
        clear_queues();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive_rand0(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b1) $display("FAIL rst_mid_full got=%b want=1", out_valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); else n_pass++;
        n_total++; if (out !== 9'h000) $display("FAIL rst_mid_out got=%h want=000", out); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        clear_queues();
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_total++; if (stale != 0) $display("FAIL rst_mid_stale got=%0d want=0", stale); else n_pass++;
        @(posedge clk); #1;
        drive_rand0(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= S0; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'(i == S0))
                $display("FAIL rst_mid_latency%0d out_valid got=%b want=%b", i, out_valid, (i == S0));
            else n_pass++;
        end
        n_total++;
        if (exp_q.size() < 1 || out !== exp_q[0]) $display("FAIL rst_mid_value got=%h want=%h", out, exp_q[0]);
        else n_pass++;
    endtask

    task automatic test_stages1();
        @(posedge clk); #1;
        clear_queues();
        s1_a = 16'hFFFF; s1_d = 16'd2; s1_b = 16'h0100; s1_op = OP_XOR; s1_c = 16'h00FF; s1_sub = 1'b0;
        s1_out_ready = 1'b1; s1_in_valid = 1'b1;
        @(negedge clk);
        n_total++; if (s1_out_valid !== 1'b0) $display("FAIL s1_pre_valid got=%b want=0", s1_out_valid); else n_pass++;
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        @(negedge clk);
        n_total++; if (s1_out_valid !== 1'b1) $display("FAIL s1_latency got=%b want=1", s1_out_valid); else n_pass++;
        n_total++; if (s1_out !== 16'h01FF) $display("FAIL s1_xor_value got=%h want=01ff", s1_out); else n_pass++;
    endtask

    task automatic test_random_stream();
        logic stall_prev;
        logic [W0-1:0] prev_out;
        stall_prev = 1'b0; prev_out = '0;
        @(posedge clk); #1;
        clear_queues();
        for (int i = 0; i < 60; i++) begin
            drive_rand0(); drive_rand1();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            s1_in_valid = ($urandom_range(0, 3) != 0);
            s1_out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stall_prev) begin
                n_total++;
                if (out_valid !== 1'b1 || out !== prev_out)
                    $display("FAIL rand_stall_hold cyc=%0d got=%b/%h want=1/%h", i, out_valid, out, prev_out);
                else n_pass++;
            end
            stall_prev = out_valid && !out_ready;
            prev_out = out;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; s1_in_valid = 1'b0; out_ready = 1'b1; s1_out_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if (obs_q.size() != exp_q.size() || exp_q.size() == 0)
            $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int j = 0; j < exp_q.size(); j++) begin
            n_total++;
            if (obs_q[j] !== exp_q[j]) $display("FAIL rand_beat%0d got=%h want=%h", j, obs_q[j], exp_q[j]);
            else n_pass++;
        end
        n_total++;
        if (obs1_q.size() != exp1_q.size() || exp1_q.size() == 0)
            $display("FAIL rand_s1_count got=%0d want=%0d", obs1_q.size(), exp1_q.size());
        else n_pass++;
        for (int j = 0; j < exp1_q.size(); j++) begin
            n_total++;
            if (obs1_q[j] !== exp1_q[j]) $display("FAIL rand_s1_beat%0d got=%h want=%h", j, obs1_q[j], exp1_q[j]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_stages1();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_preadd_mul_logic.md
PIPELINED_PREADD_MUL_LOGIC -- requirements
Module: pipelined_preadd_mul_logic

Interface
REQ-001 Parameter WIDTH, default 9: width of every data operand and of the result; legal range 2..27.
REQ-002 Parameter STAGES, default 3: pipeline depth in register stages; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
REQ-007 a, b, c, d  input  WIDTH each  unsigned operands.
REQ-008 op  input  2  logic-stage select (op_e): 0 AND, 1 OR, 2 XOR, 3 PASS.
REQ-009 sub  input  1  pre-adder mode: 0 computes d+a, 1 computes d-a.
REQ-010 out_valid  output  1  result beat presented.
REQ-011 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-012 out  output  WIDTH  result.

Function
REQ-013 Result of an accepted beat SHALL be L(P, c), where P = ((sub ? d-a : d+a) * b) mod 2^WIDTH and L is AND/OR/XOR with c, or P unchanged for PASS.
REQ-014 All intermediate arithmetic SHALL wrap modulo 2^WIDTH; no saturation, no overflow flag.
REQ-015 op, sub and the operands SHALL be sampled together at acceptance; later changes SHALL NOT affect an in-flight beat.
REQ-016 The full arithmetic SHALL be complete before stage-0 registers; stages 1..STAGES-1 SHALL be pure delay stages, each holding one data word and one valid bit.
REQ-017 out and out_valid SHALL be driven directly from stage STAGES-1 registers.
REQ-018 With out_ready held high, an accepted beat SHALL appear with out_valid high exactly STAGES cycles after its acceptance edge; sustained throughput one beat per cycle.
REQ-019 Stage k SHALL load from stage k-1 when stage k is empty or stage k is itself advancing (bubble collapse); otherwise it SHALL hold.
REQ-020 Output stage advances when out_ready or !out_valid.
REQ-021 in_ready SHALL equal !valid[0] || stage-0 advancing; combinational, no dependency on in_valid.
REQ-022 With out_ready low, the pipeline SHALL absorb up to STAGES beats, then deassert in_ready; no beat SHALL be lost, duplicated or reordered.
REQ-023 out SHALL stay stable while out_valid && !out_ready.
REQ-024 Simultaneous accept at input and drain at output in a full pipeline SHALL be allowed in the same cycle.
REQ-025 Data registers of empty stages are don't-care; only valid bits define occupancy.

Reset
REQ-026 rst_n low SHALL immediately clear every valid bit; out_valid = 0, in_ready = 1 once released.
REQ-027 out SHALL reset to 0; all data registers reset to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; none SHALL emerge after release.
REQ-029 First acceptance possible on the first rising edge with rst_n high.

Structure
REQ-030 Package pipelined_preadd_mul_logic_pkg SHALL hold typedef op_e (OP_AND, OP_OR, OP_XOR, OP_PASS) and constant MAX_STAGES = 8.
REQ-031 One sub-module, pipe_stage (WIDTH data + valid, load/hold control, async reset), SHALL be instantiated STAGES times via generate.
REQ-032 Datapath function (pre-add, multiply, logic) SHALL be a single combinational block in the top module.

Verification (WIDTH=9, STAGES=3 unless stated)
REQ-033 a=3, d=5, b=7, c=0x1FF, op=AND, sub=0, out_ready=1 -> out=56 (0x038) with out_valid high exactly 3 cycles after accept.
REQ-034 a=0x1FF, d=1, b=9, op=PASS -> pre-add wraps to 0, out=0; d=2, a=5, b=2, sub=1, c=0x005, op=OR -> out=0x1FF (0x1FA|0x005).
REQ-035 10 back-to-back beats, op cycling AND/OR/XOR/PASS, out_ready=1 -> 10 consecutive out_valid cycles, results match model in order.
REQ-036 Continuous in_valid, out_ready low 5 cycles -> in_ready low after 3 accepts, out held stable, then all beats drain in order with no loss.
REQ-037 rst_n pulsed low with 3 beats in flight -> out_valid 0 immediately, no stale beat after release, next beat has latency 3.
REQ-038 STAGES=1, WIDTH=16, a=0xFFFF, d=2, b=0x100, op=XOR, c=0x00FF -> out=0x01FF one cycle after accept.
